// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller for a 5-stage pipeline: per-register stall vector,
// exception flush sequencing (deferred while MEM is busy), stall watchdog and stall-cycle counter.
module pipeline_stall_ctrl #(
    parameter int ADDR_WIDTH    = 32,
    parameter int STALL_TIMEOUT = 255,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_req_if,
    input  logic                  stall_req_id,
    input  logic                  stall_req_ex,
    input  logic                  stall_req_mem,
    input  logic                  exception_in,
    input  logic [ADDR_WIDTH-1:0] exc_pc_in,
    output logic [4:0]            stall_out,
    output logic                  flush,
    output logic [ADDR_WIDTH-1:0] flush_pc,
    output logic                  stall_timeout,
    output logic [31:0]           stall_cycle_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(STALL_TIMEOUT);

    state_t                  state_reg, state_next;
    logic                    latch_pc;
    logic                    flush_reg;
    logic [ADDR_WIDTH-1:0]   flush_pc_reg;
    logic [CNT_WIDTH-1:0]    cnt_reg, cnt_next;
    logic                    timeout_reg;
    logic [31:0]             cycle_count_reg;

    logic [3:0]              req;
    logic [4:0]              stall_vec;

    assign req = {stall_req_mem, stall_req_ex, stall_req_id, stall_req_if};

    // A register holds whenever any stage at or beyond it asks for a stall,
    // so the deepest requester determines how far back the freeze reaches.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_stall_bit
            assign stall_vec[gi] = |req[3:gi];
        end
    endgenerate
    assign stall_vec[4] = 1'b0;

    assign stall_out = (state_reg == ST_FLUSH) ? 5'b00000 : stall_vec;

    always_comb begin
        state_next = state_reg;
        latch_pc   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (exception_in) begin
                    latch_pc   = 1'b1;
                    state_next = stall_req_mem ? ST_PENDING : ST_FLUSH;
                end
            end
            ST_PENDING: begin
                if (!stall_req_mem) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (stall_out == 5'b00000) begin
            cnt_next = '0;
        end else if (cnt_reg != {CNT_WIDTH{1'b1}}) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            flush_reg       <= 1'b0;
            flush_pc_reg    <= '0;
            cnt_reg         <= '0;
            timeout_reg     <= 1'b0;
            cycle_count_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            flush_reg <= (state_next == ST_FLUSH);
            if (latch_pc) begin
                flush_pc_reg <= exc_pc_in;
            end
            cnt_reg <= cnt_next;
            // Sticky until reset so software can observe a past hang.
            if (cnt_reg == TIMEOUT_CNT) begin
                timeout_reg <= 1'b1;
            end
            if (stall_out[0]) begin
                cycle_count_reg <= cycle_count_reg + 32'd1;
            end
        end
    end

    assign flush             = flush_reg;
    assign flush_pc          = flush_pc_reg;
    assign stall_timeout     = timeout_reg;
    assign stall_cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: vector tables per scenario, expected
// records queued on drive and popped/compared when the DUT output is sampled.
module tb_pipeline_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_req_if = 1'b0;
    logic        stall_req_id = 1'b0;
    logic        stall_req_ex = 1'b0;
    logic        stall_req_mem = 1'b0;
    logic        exception_in = 1'b0;
    logic [31:0] exc_pc_in = 32'd0;
    logic [4:0]  stall_out;
    logic        flush;
    logic [31:0] flush_pc;
    logic        stall_timeout;
    logic [31:0] stall_cycle_count;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(
        .ADDR_WIDTH   (32),
        .STALL_TIMEOUT(4),
        .CNT_WIDTH    (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_req_if     (stall_req_if),
        .stall_req_id     (stall_req_id),
        .stall_req_ex     (stall_req_ex),
        .stall_req_mem    (stall_req_mem),
        .exception_in     (exception_in),
        .exc_pc_in        (exc_pc_in),
        .stall_out        (stall_out),
        .flush            (flush),
        .flush_pc         (flush_pc),
        .stall_timeout    (stall_timeout),
        .stall_cycle_count(stall_cycle_count)
    );

    typedef struct {
        logic        rst;
        logic        rif;
        logic        rid;
        logic        rex;
        logic        rmem;
        logic        exc;
        logic [31:0] pc;
        logic [4:0]  stall;
        logic        flush;
        logic [31:0] fpc;
        logic        chk_to;
        logic        to;
    } vec_t;

    vec_t  vecs[$];
    vec_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    string seq_name;

    function automatic vec_t mk(logic r, logic rif, logic rid, logic rex, logic rmem,
                                logic exc, logic [31:0] pc, logic [4:0] stall,
                                logic fl, logic [31:0] fpc, logic chk_to, logic to);
        vec_t v;
        v.rst = r; v.rif = rif; v.rid = rid; v.rex = rex; v.rmem = rmem;
        v.exc = exc; v.pc = pc; v.stall = stall; v.flush = fl; v.fpc = fpc;
        v.chk_to = chk_to; v.to = to;
        return v;
    endfunction

    task automatic check(string what, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", what, act, exp);
        end
    endtask

    task automatic run_vecs();
        vec_t e;
        foreach (vecs[i]) begin
            @(negedge clk);
            rst           = vecs[i].rst;
            stall_req_if  = vecs[i].rif;
            stall_req_id  = vecs[i].rid;
            stall_req_ex  = vecs[i].rex;
            stall_req_mem = vecs[i].rmem;
            exception_in  = vecs[i].exc;
            exc_pc_in     = vecs[i].pc;
            sb.push_back(vecs[i]);
            #1;
            e = sb.pop_front();
            check($sformatf("%s[%0d] stall_out", seq_name, i), 32'(stall_out), 32'(e.stall));
            check($sformatf("%s[%0d] flush", seq_name, i), 32'(flush), 32'(e.flush));
            check($sformatf("%s[%0d] flush_pc", seq_name, i), flush_pc, e.fpc);
            if (e.chk_to) begin
                check($sformatf("%s[%0d] stall_timeout", seq_name, i),
                      32'(stall_timeout), 32'(e.to));
            end
            $display("%s[%0d] req=%b%b%b%b exc=%b rst=%b -> stall=%b flush=%b pc=%08h to=%b cnt=%0d",
                     seq_name, i, e.rmem, e.rex, e.rid, e.rif, e.exc, e.rst,
                     stall_out, flush, flush_pc, stall_timeout, stall_cycle_count);
        end
        vecs.delete();
    endtask

    task automatic check_count(string what, logic [31:0] exp);
        @(negedge clk);
        #1;
        check(what, stall_cycle_count, exp);
        $display("%s: stall_cycle_count=%0d", what, stall_cycle_count);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Reset state and request priority
        seq_name = "req";
        vecs.push_back(mk(0, 0,0,0,0, 0, 32'h0, 5'b00000, 0, 32'h0, 1, 0));
        vecs.push_back(mk(0, 1,0,0,0, 0, 32'h0, 5'b00001, 0, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0,1,0,0, 0, 32'h0, 5'b00011, 0, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0,0,1,0, 0, 32'h0, 5'b00111, 0, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0,0,0,1, 0, 32'h0, 5'b01111, 0, 32'h0, 0, 0));
        vecs.push_back(mk(0, 1,0,0,1, 0, 32'h0, 5'b01111, 0, 32'h0, 0, 0));
        vecs.push_back(mk(1, 0,1,0,0, 0, 32'h0, 5'b00011, 0, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0,0,0,0, 0, 32'h0, 5'b00000, 0, 32'h0, 1, 0));
        run_vecs();

        // Immediate flush; requests and exceptions masked during the flush cycle
        seq_name = "imm";
        vecs.push_back(mk(0, 0,0,0,0, 1, 32'hBFC00380, 5'b00000, 0, 32'h0,       0, 0));
        vecs.push_back(mk(0, 0,0,1,0, 1, 32'hDEAD0000, 5'b00000, 1, 32'hBFC00380, 0, 0));
        vecs.push_back(mk(0, 0,0,1,0, 0, 32'h0,        5'b00111, 0, 32'hBFC00380, 0, 0));
        vecs.push_back(mk(0, 0,0,0,0, 0, 32'h0,        5'b00000, 0, 32'hBFC00380, 0, 0));
        run_vecs();

        // Deferred flush while MEM busy; second exception ignored
        seq_name = "def";
        vecs.push_back(mk(0, 0,0,0,1, 1, 32'h80000180, 5'b01111, 0, 32'hBFC00380, 0, 0));
        vecs.push_back(mk(0, 0,0,0,1, 0, 32'h0,        5'b01111, 0, 32'h80000180, 0, 0));
        vecs.push_back(mk(0, 0,0,0,1, 1, 32'h00001234, 5'b01111, 0, 32'h80000180, 0, 0));
        vecs.push_back(mk(0, 0,0,0,1, 0, 32'h0,        5'b01111, 0, 32'h80000180, 0, 0));
        vecs.push_back(mk(0, 0,0,0,1, 0, 32'h0,        5'b01111, 0, 32'h80000180, 0, 0));
        vecs.push_back(mk(0, 0,0,0,0, 0, 32'h0,        5'b00000, 0, 32'h80000180, 0, 0));
        vecs.push_back(mk(0, 0,0,0,0, 0, 32'h0,        5'b00000, 1, 32'h80000180, 0, 0));
        vecs.push_back(mk(0, 0,0,0,0, 0, 32'h0,        5'b00000, 0, 32'h80000180, 0, 0));
        run_vecs();

        // Reset while PENDING discards the exception; FSM back in IDLE
        seq_name = "rstpend";
        vecs.push_back(mk(0, 0,0,0,1, 1, 32'h55550000, 5'b01111, 0, 32'h80000180, 0, 0));
        vecs.push_back(mk(0, 0,0,0,1, 0, 32'h0,        5'b01111, 0, 32'h55550000, 0, 0));
        vecs.push_back(mk(1, 0,0,0,1, 0, 32'h0,        5'b01111, 0, 32'h55550000, 0, 0));
        vecs.push_back(mk(0, 0,0,0,0, 0, 32'h0,        5'b00000, 0, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0,0,0,0, 0, 32'h0,        5'b00000, 0, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0,0,0,0, 1, 32'h00000100, 5'b00000, 0, 32'h0,        0, 0));
        vecs.push_back(mk(0, 0,0,0,0, 0, 32'h0,        5'b00000, 1, 32'h00000100, 0, 0));
        vecs.push_back(mk(0, 0,0,0,0, 0, 32'h0,        5'b00000, 0, 32'h00000100, 0, 0));
        run_vecs();

        // Watchdog with timeout 4: short burst stays clear, long burst trips it
        seq_name = "wdog";
        vecs.push_back(mk(1, 0,0,0,0, 0, 32'h0, 5'b00000, 0, 32'h00000100, 0, 0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0, 0,0,1,0, 0, 32'h0, 5'b00111, 0, 32'h0, 1, 0));
        vecs.push_back(mk(0, 0,0,0,0, 0, 32'h0, 5'b00000, 0, 32'h0, 1, 0));
        for (int k = 0; k < 6; k++)
            vecs.push_back(mk(0, 0,0,1,0, 0, 32'h0, 5'b00111, 0, 32'h0, 1, (k == 5)));
        for (int k = 0; k < 2; k++)
            vecs.push_back(mk(0, 0,0,0,0, 0, 32'h0, 5'b00000, 0, 32'h0, 1, 1));
        run_vecs();

        // Stall-cycle counter: 10 ex + 3 idle + 7 if cycles
        seq_name = "cnt";
        vecs.push_back(mk(1, 0,0,0,0, 0, 32'h0, 5'b00000, 0, 32'h0, 0, 0));
        run_vecs();
        check_count("cnt_after_reset", 32'd0);
        for (int k = 0; k < 10; k++)
            vecs.push_back(mk(0, 0,0,1,0, 0, 32'h0, 5'b00111, 0, 32'h0, 0, 0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0, 0,0,0,0, 0, 32'h0, 5'b00000, 0, 32'h0, 0, 0));
        for (int k = 0; k < 7; k++)
            vecs.push_back(mk(0, 1,0,0,0, 0, 32'h0, 5'b00001, 0, 32'h0, 0, 0));
        run_vecs();
        check_count("cnt_total", 32'd17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB registers). It collects stall requests from the IF, ID, EX and MEM stages and produces a per-register stall vector; each pipeline register takes bit i as stall_current_stage and bit i+1 as stall_next_stage. It sequences exception flushes, deferring them while MEM is busy, and keeps a stall watchdog and a stall-cycle performance counter.

Parameters:
ADDR_WIDTH, 32, width of PC / handler address
STALL_TIMEOUT, 255, consecutive stalled cycles that trip the watchdog (1..2^CNT_WIDTH-1)
CNT_WIDTH, 8, width of the consecutive-stall counter

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
stall_req_if  in  1  IF stage request (icache miss)
stall_req_id  in  1  ID stage request (load-use hazard)
stall_req_ex  in  1  EX stage request (mult/div busy)
stall_req_mem  in  1  MEM stage request (dcache busy)
exception_in  in  1  exception raised by the instruction in MEM (single-cycle pulse)
exc_pc_in  in  ADDR_WIDTH  handler address, valid with exception_in
stall_out  out  5  [0]=PC, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB
flush  out  1  flush all pipeline registers and redirect PC
flush_pc  out  ADDR_WIDTH  redirect target, valid with flush
stall_timeout  out  1  sticky watchdog flag
stall_cycle_count  out  32  total cycles with stall_out[0]=1

Behaviour:
- Stall vector is combinational from the requests and the FSM state. Deepest requester wins:
  - mem -> 5'b01111
  - else ex -> 5'b00111
  - else id -> 5'b00011
  - else if -> 5'b00001
  - else 5'b00000
- stall_out[4] is always 0. MEM/WB is never held; stall_next_stage of MEM/WB is tied 0. A stage whose own bit is set while the next bit is clear emits a bubble.
- Flush FSM states:
  - IDLE: exception_in && !stall_req_mem -> FLUSH; latch exc_pc_in. exception_in && stall_req_mem -> PENDING; latch exc_pc_in.
  - PENDING: hold the latched PC and ignore further exception_in. When stall_req_mem is 0 in a cycle -> FLUSH next cycle.
  - FLUSH: lasts exactly one cycle with flush=1, flush_pc=latched PC, stall_out forced to 5'b00000 regardless of requests. exception_in is ignored. Next state is IDLE.
- flush and flush_pc are registered: exception at cycle N with MEM not busy gives flush=1 at N+1 only.
- Outside FLUSH, flush=0 and flush_pc holds its last latched value.
- Watchdog:
  - CNT_WIDTH counter increments each cycle stall_out!=0 and clears to 0 on a cycle with stall_out==0. It saturates at all-ones.
  - When the counter equals STALL_TIMEOUT, stall_timeout is set next cycle and stays set until rst.
- stall_cycle_count increments on every cycle with stall_out[0]=1 (including PENDING) and wraps modulo 2^32.
- Reset values: state=IDLE, flush=0, flush_pc=0, consecutive counter=0, stall_timeout=0, stall_cycle_count=0. stall_out follows the requests combinationally (not gated by rst).
- Reset mid-operation: rst during PENDING or FLUSH forces IDLE next cycle; the pending exception is discarded and flush=0.
- Simultaneous events:
  - exception_in together with stall_req_mem in IDLE goes to PENDING, never directly to FLUSH.
  - A request arriving during FLUSH is masked that cycle and takes effect the following cycle.

Test Plan:
- Requests only: drive if=1 / id=1 / ex=1 / mem=1 one at a time, then if=1 with mem=1 together -> stall_out = 00001, 00011, 00111, 01111, 01111. flush stays 0.
- Immediate flush: exception_in=1, exc_pc_in=0xBFC00380, stall_req_mem=0 at cycle 10 -> flush=1 and flush_pc=0xBFC00380 at cycle 11 only, with stall_out=00000 at 11 even if ex=1. flush=0 at 12.
- Deferred flush: stall_req_mem=1 cycles 10..14, exception with pc 0x80000180 at 10, second exception with pc 0x1234 at 12 -> flush=0 through 14, flush=1 at 16 with pc 0x80000180 (mem drops at 15). stall_out=01111 during 10..14.
- Reset mid-PENDING: enter PENDING at cycle 5, rst=1 at cycle 7, mem released at 8 -> flush never asserts; state IDLE.
- Watchdog: STALL_TIMEOUT=4, ex=1 for 3 cycles, one free cycle, then ex=1 for 6 cycles -> stall_timeout stays 0 through the first burst. It rises 1 cycle after the 5th stalled cycle of the second burst and stays 1 after ex drops.
- Counter: 10 cycles ex=1, 3 idle, 7 cycles if=1 -> stall_cycle_count=17. Preload near 0xFFFFFFFF via long stall and confirm it wraps to 0.
